elastic_buf: RTL and testbench
==============================

# elastic_buf

Parametrised elastic FIFO buffer for linear pipelines. It generalises the two-entry double buffer to N entries with configurable data width. It keeps the registered upstream accept, the stall request and the head-of-queue output register, and adds a synchronous flush and an occupancy output. It sits between two pipeline stages to absorb backpressure bubbles without a combinational accept path.

## Interface

- W, 32: data width in bits, ≥1.
- N, 4: depth in entries, power of two, ≥2.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_vld  in  1  upstream data valid.
- in_w  in  W  upstream data.
- in_accept_r  out  1  registered accept; a push occurs when in_vld & in_accept_r.
- out_accept  in  1  downstream ready.
- out_vld_r  out  1  head entry valid.
- out_r  out  W  head entry data.
- stall_req  in  1  requests upstream hold; gates next-cycle accept.
- flush  in  1  synchronous discard of all entries.
- count_r  out  $clog2(N+1)  current occupancy, 0..N.

## Operation

- Storage: N×W array, rd_ptr/wr_ptr of $clog2(N) bits, natural wrap modulo N. count_r tracks occupancy; full means count_r==N, empty means count_r==0.
- push = in_vld & in_accept_r. pop = out_vld_r & out_accept.
- Next occupancy: count_w = count_r + push − pop. Push+pop in the same cycle leaves the count unchanged, and both pointers advance.
- Push writes mem[wr_ptr] and increments wr_ptr. Pop increments rd_ptr.
- out_vld_r = (count_r != 0). out_r = mem[rd_ptr]. Data leaves in strict FIFO order.
- in_accept_r <= ~stall_req & (count_w < N) & ~flush.
  - Accept is computed from the post-update count, so a push is never accepted while full.
  - This is conservative: a pop in the cycle after the decision is not credited.
- push while full cannot occur by construction. The bench asserts this.
- flush (highest priority below rst):
  - count_r, rd_ptr and wr_ptr clear to 0.
  - Any same-cycle push or pop is discarded.
  - in_accept_r <= 0 for that cycle's update only.
- States, implied by count_r: EMPTY (0), PARTIAL (1..N−1), FULL (N). Transitions:
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop at N−1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without push at 1.
  - Any state→EMPTY on flush or rst.
- The storage array is not reset. out_r is unspecified while out_vld_r=0.

## Timing

- Reset values: in_accept_r=0, out_vld_r=0, count_r=0. rst mid-operation drops all contents at the next edge.
- in_accept_r first rises on the first clock edge with rst low, provided stall_req=0.
- Latency: a push at edge t into an empty buffer gives out_vld_r=1 with that data after edge t. This is a 1-cycle latency.
- Throughput: 1 entry/cycle sustained when out_accept=1 and stall_req=0, with no bubbles.
- stall_req at cycle t deasserts in_accept_r after edge t. A push is still honoured at t if in_accept_r was already 1.
- From full, the first pop at edge t re-raises in_accept_r after edge t.
- flush at edge t gives out_vld_r=0 and count_r=0 after t. in_accept_r is 0 for one cycle, then re-evaluates.

## Test plan

- **Reset:** rst=1 for 3 cycles, then 0, with stall_req=0.
  - in_accept_r, out_vld_r and count_r are 0 throughout reset.
  - in_accept_r=1 one edge after rst falls.
- **Fill/drain (N=4):** out_accept=0, push 0x11, 0x22, 0x33, 0x44 back-to-back, then hold 0x55 valid.
  - count_r goes 1, 2, 3, 4 and in_accept_r=0 after the 4th push; 0x55 is not taken.
  - Set out_accept=1: outputs are 0x11, 0x22, 0x33, 0x44, then 0x55.
  - in_accept_r is 1 the cycle after the first pop.
- **Streaming:** out_accept=1, push 0..15 on consecutive cycles.
  - out_r is 0..15 on consecutive cycles with count_r constant at 1.
  - Pointers wrap 4 times; there are no gaps.
- **Push+pop at count 3:** simultaneous push of 0xA0 and pop of the head.
  - count_r stays 3 and 0xA0 becomes the tail.
  - out_r is the previous second entry.
- **Stall:** stall_req=1 for 3 cycles with count_r=1 and out_accept=1.
  - in_accept_r is 0 for 3 cycles, lagging stall_req by one edge.
  - The stored entry still drains.
- **Flush:** count_r=3 with a concurrent push of 0xBB and flush=1.
  - Next cycle: count_r=0, out_vld_r=0, in_accept_r=0.
  - A later push of 0xAA appears as out_r=0xAA; 0xBB never appears.

Source files
------------

// File: rtl/elastic_buf.sv
// elastic_buf: N-entry elastic FIFO between two pipeline stages.
// The upstream accept is registered, so no combinational path runs from
// out_accept to in_accept_r. Head data is read straight from storage.
//
// Occupancy states, implied by count_r (no separate state register):
//   state   | meaning
//   EMPTY   | count_r == 0, out_vld_r low
//   PARTIAL | 0 < count_r < N
//   FULL    | count_r == N, accept held low
module elastic_buf #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  input  logic [W-1:0]           in_w,
  output logic                   in_accept_r,
  input  logic                   out_accept,
  output logic                   out_vld_r,
  output logic [W-1:0]           out_r,
  input  logic                   stall_req,
  input  logic                   flush,
  output logic [$clog2(N+1)-1:0] count_r
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N+1);

  logic [W-1:0]  mem_q [N];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          accept_q, accept_d;
  logic          push, pop;
  logic [CW-1:0] count_w;

  assign push = in_vld & accept_q;
  assign pop  = (count_q != '0) & out_accept;

  // Occupancy after this edge, used both as next count and for the accept decision.
  // Accept looks at the post-update count, so a pop next cycle is not credited.
  always_comb begin
    count_w  = count_q + CW'(push) - CW'(pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_w;
    accept_d = ~stall_req & (count_w < CW'(N)) & ~flush;
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control registers; reset and flush drop every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      accept_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      accept_q <= accept_d;
    end
  end

  // Storage write; contents are never reset, validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push & ~flush & ~rst) mem_q[wr_ptr_q] <= in_w;
  end

  assign in_accept_r = accept_q;
  assign out_vld_r   = (count_q != '0);
  assign out_r       = mem_q[rd_ptr_q];
  assign count_r     = count_q;

endmodule

// File: tb/tb_elastic_buf.sv
// Bench for elastic_buf (W=32, N=4): queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_elastic_buf;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_vld;
  logic [W-1:0] in_w;
  logic         in_accept_r;
  logic         out_accept;
  logic         out_vld_r;
  logic [W-1:0] out_r;
  logic         stall_req;
  logic         flush;
  logic [2:0]   count_r;

  int checks   = 0;
  int failures = 0;

  elastic_buf #(.W(W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_vld     (in_vld),
    .in_w       (in_w),
    .in_accept_r(in_accept_r),
    .out_accept (out_accept),
    .out_vld_r  (out_vld_r),
    .out_r      (out_r),
    .stall_req  (stall_req),
    .flush      (flush),
    .count_r    (count_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue holding the buffer contents in order.
  logic [W-1:0] mq[$];
  bit           m_acc = 1'b0;

  always @(posedge clk) begin
    bit p, q;
    if (!rst && !flush && in_vld && in_accept_r && count_r == 3'(N))
      chk("push_while_full", 1, 0);
    p = in_vld && m_acc;
    q = (mq.size() != 0) && out_accept;
    if (rst || flush) begin
      mq.delete();
      m_acc = 1'b0;
    end else begin
      if (q) void'(mq.pop_front());
      if (p) mq.push_back(in_w);
      m_acc = !stall_req && (mq.size() < N);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_count", 32'(count_r), 32'(mq.size()));
    chk("m_vld", 32'(out_vld_r), 32'(mq.size() != 0));
    chk("m_acc", 32'(in_accept_r), 32'(m_acc));
    if (mq.size() != 0) chk("m_data", out_r, mq[0]);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic oa);
    in_vld     = v;
    in_w       = d;
    out_accept = oa;
  endtask

  initial begin
    logic [31:0] fill [4];
    rst = 1'b1; in_vld = 1'b0; in_w = '0; out_accept = 1'b0;
    stall_req = 1'b0; flush = 1'b0;

    // Reset
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_acc", 32'(in_accept_r), 0);
      chk("rst_vld", 32'(out_vld_r), 0);
      chk("rst_cnt", 32'(count_r), 0);
    end
    rst = 1'b0;
    tick();
    chk("acc_after_rst", 32'(in_accept_r), 1);

    // Fill and drain
    fill[0] = 32'h11; fill[1] = 32'h22; fill[2] = 32'h33; fill[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill[i], 1'b0);
      tick();
      chk("fill_cnt", 32'(count_r), 32'(i + 1));
    end
    chk("full_acc", 32'(in_accept_r), 0);
    drive(1'b1, 32'h55, 1'b0);
    tick();
    chk("full_hold_cnt", 32'(count_r), 4);
    chk("full_head", out_r, 32'h11);
    drive(1'b1, 32'h55, 1'b1);
    tick();
    chk("pop1_acc", 32'(in_accept_r), 1);
    chk("pop1_cnt", 32'(count_r), 3);
    chk("pop1_head", out_r, 32'h22);
    tick();
    chk("pop2_cnt", 32'(count_r), 3);
    chk("pop2_head", out_r, 32'h33);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("pop3_head", out_r, 32'h44);
    tick();
    chk("pop4_head", out_r, 32'h55);
    tick();
    chk("drained_vld", 32'(out_vld_r), 0);

    // Streaming 0..15 with pointer wrap
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i), 1'b1);
      tick();
      chk("stream_data", out_r, 32'(i));
      chk("stream_cnt", 32'(count_r), 1);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("stream_end_cnt", 32'(count_r), 0);

    // Simultaneous push and pop at count 3
    drive(1'b1, 32'hC1, 1'b0); tick();
    drive(1'b1, 32'hC2, 1'b0); tick();
    drive(1'b1, 32'hC3, 1'b0); tick();
    chk("pp_pre_cnt", 32'(count_r), 3);
    drive(1'b1, 32'hA0, 1'b1);
    tick();
    chk("pp_cnt", 32'(count_r), 3);
    chk("pp_head", out_r, 32'hC2);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("pp_next", out_r, 32'hC3);
    tick();
    chk("pp_tail", out_r, 32'hA0);
    tick();
    chk("pp_empty", 32'(count_r), 0);

    // Stall
    drive(1'b1, 32'hD1, 1'b0);
    tick();
    chk("st_pre_cnt", 32'(count_r), 1);
    stall_req = 1'b1;
    drive(1'b1, 32'hD2, 1'b1);
    tick();
    chk("st1_acc", 32'(in_accept_r), 0);
    chk("st1_head", out_r, 32'hD2);
    drive(1'b1, 32'hD3, 1'b1);
    tick();
    chk("st2_acc", 32'(in_accept_r), 0);
    tick();
    chk("st3_acc", 32'(in_accept_r), 0);
    chk("st3_cnt", 32'(count_r), 0);
    stall_req = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("st_release_acc", 32'(in_accept_r), 1);
    chk("st_release_cnt", 32'(count_r), 0);

    // Flush with concurrent push
    drive(1'b1, 32'hE1, 1'b0); tick();
    drive(1'b1, 32'hE2, 1'b0); tick();
    drive(1'b1, 32'hE3, 1'b0); tick();
    chk("fl_pre_cnt", 32'(count_r), 3);
    drive(1'b1, 32'hBB, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_cnt", 32'(count_r), 0);
    chk("fl_vld", 32'(out_vld_r), 0);
    chk("fl_acc", 32'(in_accept_r), 0);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("fl_reacc", 32'(in_accept_r), 1);
    drive(1'b1, 32'hAA, 1'b0);
    tick();
    chk("fl_new_head", out_r, 32'hAA);
    chk("fl_new_cnt", 32'(count_r), 1);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("fl_drained", 32'(out_vld_r), 0);

    // Reset mid-operation
    drive(1'b1, 32'hF1, 1'b0); tick();
    drive(1'b1, 32'hF2, 1'b0);
    rst = 1'b1;
    tick();
    chk("mrst_cnt", 32'(count_r), 0);
    chk("mrst_acc", 32'(in_accept_r), 0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("mrst_reacc", 32'(in_accept_r), 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
